// File: rtl/lcd_bus_receiver.sv
// Decodes HD44780-style 4-bit LCD writes (init 0x3,0x3,0x3,0x2 then nibble pairs) into bytes; strobes 1 cycle after E falls.
// Define LCD_RX_TIMING_CHECK_EN to enable E high/low width checking (oTimingError); otherwise every event is accepted.
module lcd_bus_receiver #(
  parameter int unsigned MIN_E_HIGH = 12,
  parameter int unsigned MIN_E_LOW  = 12
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       iLCD_Enabled,
  input  logic       iLCD_RegisterSelect,
  input  logic       iLCD_ReadWrite,
  input  logic [3:0] iLCD_Data,
  output logic [7:0] oByte,
  output logic       oByteIsData,
  output logic       oByteValid,
  output logic       oMode4Bit,
  output logic       oSeqError,
  output logic       oTimingError
);

  typedef enum logic [1:0] {ST_INIT, ST_HIGH, ST_LOW} state_t;

  // Width counters saturate at 255, so larger thresholds could never be met.
  if (MIN_E_HIGH > 255 || MIN_E_LOW > 255) begin : g_param_chk
    $error("MIN_E_HIGH/MIN_E_LOW must not exceed 255");
  end

  logic       e_q;
  logic [3:0] nib_q;
  logic       rs_q, rw_q;
  logic       evt;
  logic       timing_ok;

  assign evt = e_q & ~iLCD_Enabled;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      e_q   <= 1'b0;
      nib_q <= 4'h0;
      rs_q  <= 1'b0;
      rw_q  <= 1'b0;
    end else begin
      e_q <= iLCD_Enabled;
      if (iLCD_Enabled) begin
        nib_q <= iLCD_Data;
        rs_q  <= iLCD_RegisterSelect;
        rw_q  <= iLCD_ReadWrite;
      end
    end
  end

  state_t     st_q, st_d;
  logic [1:0] cnt_q, cnt_d;
  logic [3:0] hi_nib_q, hi_nib_d;
  logic       hi_rs_q, hi_rs_d;
  logic [7:0] byte_q, byte_d;
  logic       isd_q, isd_d;
  logic       vld_q, vld_d;
  logic       mode_q, mode_d;
  logic       seq_q, seq_d;

`ifdef LCD_RX_TIMING_CHECK_EN
  localparam logic [7:0] MinHi = 8'(MIN_E_HIGH);
  localparam logic [7:0] MinLo = 8'(MIN_E_LOW);

  logic [7:0] hi_cnt_q, lo_cnt_q, gap_q;
  logic       tim_q, tim_d;

  // Counts include the current cycle, so at the event hi_cnt_q equals the full pulse width.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      hi_cnt_q <= 8'd0;
      lo_cnt_q <= 8'd0;
      gap_q    <= 8'd0;
    end else if (iLCD_Enabled) begin
      hi_cnt_q <= !e_q ? 8'd1 : (hi_cnt_q == 8'hFF) ? 8'hFF : hi_cnt_q + 8'd1;
      if (!e_q) gap_q <= lo_cnt_q;
    end else begin
      lo_cnt_q <= e_q ? 8'd1 : (lo_cnt_q == 8'hFF) ? 8'hFF : lo_cnt_q + 8'd1;
    end
  end

  assign timing_ok = (hi_cnt_q >= MinHi) && ((st_q != ST_LOW) || (gap_q >= MinLo));
  assign tim_d     = evt & ~rw_q & ~timing_ok;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) tim_q <= 1'b0;
    else       tim_q <= tim_d;
  end

  assign oTimingError = tim_q;
`else
  assign timing_ok    = 1'b1;
  assign oTimingError = 1'b0;
`endif

  always_comb begin
    st_d     = st_q;
    cnt_d    = cnt_q;
    hi_nib_d = hi_nib_q;
    hi_rs_d  = hi_rs_q;
    byte_d   = byte_q;
    isd_d    = isd_q;
    mode_d   = mode_q;
    vld_d    = 1'b0;
    seq_d    = 1'b0;
    if (evt) begin
      if (rw_q) begin
        seq_d = 1'b1;
      end else if (timing_ok) begin
        unique case (st_q)
          ST_INIT: begin
            if (nib_q == 4'h3) begin
              if (cnt_q != 2'd3) cnt_d = cnt_q + 2'd1;
            end else if (nib_q == 4'h2 && cnt_q == 2'd3) begin
              st_d   = ST_HIGH;
              mode_d = 1'b1;
            end else begin
              cnt_d = 2'd0;
              seq_d = 1'b1;
            end
          end
          ST_HIGH: begin
            hi_nib_d = nib_q;
            hi_rs_d  = rs_q;
            st_d     = ST_LOW;
          end
          ST_LOW: begin
            if (rs_q == hi_rs_q) begin
              byte_d = {hi_nib_q, nib_q};
              isd_d  = rs_q;
              vld_d  = 1'b1;
              st_d   = ST_HIGH;
            end else begin
              // RS mismatch: restart the byte with this nibble as its high half
              seq_d    = 1'b1;
              hi_nib_d = nib_q;
              hi_rs_d  = rs_q;
            end
          end
          default: st_d = ST_INIT;
        endcase
      end
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      st_q     <= ST_INIT;
      cnt_q    <= 2'd0;
      hi_nib_q <= 4'h0;
      hi_rs_q  <= 1'b0;
      byte_q   <= 8'h00;
      isd_q    <= 1'b0;
      vld_q    <= 1'b0;
      mode_q   <= 1'b0;
      seq_q    <= 1'b0;
    end else begin
      st_q     <= st_d;
      cnt_q    <= cnt_d;
      hi_nib_q <= hi_nib_d;
      hi_rs_q  <= hi_rs_d;
      byte_q   <= byte_d;
      isd_q    <= isd_d;
      vld_q    <= vld_d;
      mode_q   <= mode_d;
      seq_q    <= seq_d;
    end
  end

  assign oByte       = byte_q;
  assign oByteIsData = isd_q;
  assign oByteValid  = vld_q;
  assign oMode4Bit   = mode_q;
  assign oSeqError   = seq_q;

endmodule

// File: tb/tb_lcd_bus_receiver.sv
// Directed bench for lcd_bus_receiver: init sequence, byte assembly, protocol errors, reset and E-width behaviour.
module tb_lcd_bus_receiver;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       e   = 1'b0;
  logic       rs  = 1'b0;
  logic       rw  = 1'b0;
  logic [3:0] d   = 4'h0;
  logic [7:0] byte_o;
  logic       isd, vld, m4, seq, tim;

  int n_cmp = 0;
  int n_bad = 0;

  lcd_bus_receiver #(.MIN_E_HIGH(12), .MIN_E_LOW(12)) dut (
    .Clock              (clk),
    .Reset              (rst),
    .iLCD_Enabled       (e),
    .iLCD_RegisterSelect(rs),
    .iLCD_ReadWrite     (rw),
    .iLCD_Data          (d),
    .oByte              (byte_o),
    .oByteIsData        (isd),
    .oByteValid         (vld),
    .oMode4Bit          (m4),
    .oSeqError          (seq),
    .oTimingError       (tim)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Idle 12 cycles, hold E high for hi cycles, drop E (bus lines scrambled), return one cycle after the event.
  task automatic nib(input logic r, input logic w, input logic [3:0] v, input int hi);
    repeat (12) begin @(posedge clk); #1; end
    e = 1'b1; rs = r; rw = w; d = v;
    repeat (hi) begin @(posedge clk); #1; end
    e = 1'b0; rs = ~r; rw = 1'b0; d = ~v;
    @(posedge clk); #1;
  endtask

  task automatic strobes(input string tag, input logic ev, input logic es, input logic em);
    check({tag, ".vld"},  {31'd0, vld}, {31'd0, ev});
    check({tag, ".seq"},  {31'd0, seq}, {31'd0, es});
    check({tag, ".mode"}, {31'd0, m4},  {31'd0, em});
  endtask

  task automatic all_zero(input string tag);
    check({tag, ".byte"}, {24'd0, byte_o}, 32'h0);
    check({tag, ".isd"},  {31'd0, isd},    32'h0);
    check({tag, ".vld"},  {31'd0, vld},    32'h0);
    check({tag, ".mode"}, {31'd0, m4},     32'h0);
    check({tag, ".seq"},  {31'd0, seq},    32'h0);
    check({tag, ".tim"},  {31'd0, tim},    32'h0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    all_zero("reset");
    rst = 1'b0;

    // Power-on init sequence
    nib(1'b0, 1'b0, 4'h3, 12); strobes("init1", 1'b0, 1'b0, 1'b0);
    nib(1'b0, 1'b0, 4'h3, 12); strobes("init2", 1'b0, 1'b0, 1'b0);
    nib(1'b0, 1'b0, 4'h3, 12); strobes("init3", 1'b0, 1'b0, 1'b0);
    nib(1'b0, 1'b0, 4'h2, 12); strobes("init4", 1'b0, 1'b0, 1'b1);
    check("init4.tim", {31'd0, tim}, 32'h0);

    // Data byte 0x41
    nib(1'b1, 1'b0, 4'h4, 12); strobes("b41_hi", 1'b0, 1'b0, 1'b1);
    nib(1'b1, 1'b0, 4'h1, 12); strobes("b41_lo", 1'b1, 1'b0, 1'b1);
    check("b41.byte", {24'd0, byte_o}, 32'h41);
    check("b41.isd",  {31'd0, isd},    32'h1);
    @(posedge clk); #1;
    check("b41.vld_drop",  {31'd0, vld},    32'h0);
    check("b41.byte_hold", {24'd0, byte_o}, 32'h41);

    // RS mismatch restarts the byte with the mismatched nibble as high half
    nib(1'b0, 1'b0, 4'h2, 12); strobes("mm_hi", 1'b0, 1'b0, 1'b1);
    nib(1'b1, 1'b0, 4'h8, 12); strobes("mm_bad", 1'b0, 1'b1, 1'b1);
    check("mm_bad.byte_hold", {24'd0, byte_o}, 32'h41);
    nib(1'b1, 1'b0, 4'h5, 12); strobes("mm_lo", 1'b1, 1'b0, 1'b1);
    check("b85.byte", {24'd0, byte_o}, 32'h85);
    check("b85.isd",  {31'd0, isd},    32'h1);

    // Read cycles are ignored but flagged
    nib(1'b0, 1'b1, 4'hF, 12); strobes("read", 1'b0, 1'b1, 1'b1);
    nib(1'b0, 1'b0, 4'h1, 12); strobes("b12_hi", 1'b0, 1'b0, 1'b1);
    nib(1'b0, 1'b0, 4'h2, 12); strobes("b12_lo", 1'b1, 1'b0, 1'b1);
    check("b12.byte", {24'd0, byte_o}, 32'h12);
    check("b12.isd",  {31'd0, isd},    32'h0);

    // Short E pulse
    nib(1'b0, 1'b0, 4'h7, 5);
`ifdef LCD_RX_TIMING_CHECK_EN
    strobes("short", 1'b0, 1'b0, 1'b1);
    check("short.tim", {31'd0, tim}, 32'h1);
    nib(1'b0, 1'b0, 4'h3, 12); strobes("b34_hi", 1'b0, 1'b0, 1'b1);
    nib(1'b0, 1'b0, 4'h4, 12); strobes("b34_lo", 1'b1, 1'b0, 1'b1);
    check("b34.byte", {24'd0, byte_o}, 32'h34);
`else
    strobes("short", 1'b0, 1'b0, 1'b1);
    check("short.tim", {31'd0, tim}, 32'h0);
    nib(1'b0, 1'b0, 4'h3, 12); strobes("b73_lo", 1'b1, 1'b0, 1'b1);
    check("b73.byte", {24'd0, byte_o}, 32'h73);
`endif

    // Reset mid-byte: asynchronous clear, stored high nibble discarded
    nib(1'b0, 1'b0, 4'h2, 12); strobes("pre_rst", 1'b0, 1'b0, 1'b1);
    rst = 1'b1;
    #2;
    all_zero("async_rst");
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    nib(1'b0, 1'b0, 4'h5, 12); strobes("post_rst", 1'b0, 1'b1, 1'b0);

    // Broken init (0x3 then 0x2), then a full init with an extra 0x3 to exercise saturation
    nib(1'b0, 1'b0, 4'h3, 12); strobes("bad_init1", 1'b0, 1'b0, 1'b0);
    nib(1'b0, 1'b0, 4'h2, 12); strobes("bad_init2", 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      nib(1'b0, 1'b0, 4'h3, 12); strobes("reinit3", 1'b0, 1'b0, 1'b0);
    end
    nib(1'b0, 1'b0, 4'h2, 12); strobes("reinit2", 1'b0, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lcd_bus_receiver.md
LCD_BUS_RECEIVER -- requirements
Module: lcd_bus_receiver

Interface
REQ-001 SHALL have parameter MIN_E_HIGH, default 12: minimum LCD_E high width in clock cycles.
REQ-002 SHALL have parameter MIN_E_LOW, default 12: minimum LCD_E low cycles between the two nibbles of a byte.
REQ-003 SHALL have port Clock, input, 1: single clock, all logic rising-edge.
REQ-004 SHALL have port Reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port iLCD_Enabled, input, 1: LCD_E strobe.
REQ-006 SHALL have port iLCD_RegisterSelect, input, 1: 0=command, 1=data.
REQ-007 SHALL have port iLCD_ReadWrite, input, 1: 0=write, 1=read.
REQ-008 SHALL have port iLCD_Data, input, 4: SF_D<11:8> nibble.
REQ-009 SHALL have port oByte, output, 8: last assembled byte.
REQ-010 SHALL have port oByteIsData, output, 1: RS of last assembled byte.
REQ-011 SHALL have port oByteValid, output, 1: one-cycle strobe for a new byte.
REQ-012 SHALL have port oMode4Bit, output, 1: power-on init sequence complete, 4-bit mode active.
REQ-013 SHALL have port oSeqError, output, 1: one-cycle strobe for an init-sequence or protocol error.
REQ-014 SHALL have port oTimingError, output, 1: one-cycle strobe for an E timing violation.

Function
REQ-015 SHALL register iLCD_Enabled as E_q; a write event occurs in the cycle E_q=1 and iLCD_Enabled=0.
REQ-016 SHALL capture iLCD_Data, iLCD_RegisterSelect and iLCD_ReadWrite every cycle iLCD_Enabled=1; the values captured in the last high cycle form the event nibble.
REQ-017 SHALL count E-high cycles, saturating at 255, reset to 0 on each rising edge of E.
REQ-018 SHALL count E-low cycles, saturating at 255, reset to 0 on each falling edge of E.
REQ-019 SHALL ignore any event with captured RW=1 and pulse oSeqError one cycle after it.
REQ-020 SHALL implement states ST_INIT, ST_HIGH, ST_LOW; reset state ST_INIT.
REQ-021 ST_INIT: nibble 0x3 SHALL increment the init count, saturating at 3.
REQ-022 ST_INIT: nibble 0x2 with count=3 SHALL enter ST_HIGH and set oMode4Bit=1.
REQ-023 ST_INIT: nibble 0x2 with count<3, or any other nibble, SHALL clear the count and pulse oSeqError.
REQ-024 ST_HIGH: an event SHALL store the nibble as bits 7:4 with its RS and enter ST_LOW.
REQ-025 ST_LOW: an event with matching RS SHALL load oByte={high,low} and oByteIsData=RS, pulse oByteValid, and enter ST_HIGH.
REQ-026 ST_LOW: an event with mismatched RS SHALL pulse oSeqError, discard the high nibble, and treat the event nibble as a new high nibble (remain in ST_LOW).
REQ-027 Latency: oByteValid/oSeqError/oTimingError SHALL assert exactly one cycle after the event cycle; oByte/oByteIsData SHALL update in the same cycle as oByteValid and hold otherwise.
REQ-028 oMode4Bit SHALL stay 1 until Reset.

Reset
REQ-029 On Reset, regardless of clock: state=ST_INIT, init count=0, counters=0, E_q=0, oByte=0x00, oByteIsData=0, oByteValid=0, oMode4Bit=0, oSeqError=0, oTimingError=0.
REQ-030 Reset mid-byte (ST_LOW) SHALL discard the stored high nibble; no oByteValid for it.

Configuration
REQ-031 With macro LCD_RX_TIMING_CHECK_EN defined, an event with E-high count < MIN_E_HIGH, or an ST_LOW event whose preceding E-low count < MIN_E_LOW, SHALL be discarded (no state change) and SHALL pulse oTimingError.
REQ-032 Without LCD_RX_TIMING_CHECK_EN, the E-width counters SHALL be omitted, oTimingError SHALL be tied to 0, and every event SHALL be processed.

Verification
REQ-033 Reset, then 12-cycle pulses of 0x3, 0x3, 0x3, 0x2 -> oMode4Bit=1 after the fourth event; no error strobes.
REQ-034 After init, RS=1 nibbles 0x4 then 0x1 -> oByteValid one cycle after the second fall, oByte=0x41, oByteIsData=1.
REQ-035 In ST_INIT, 0x3 then 0x2 -> oSeqError pulse, oMode4Bit stays 0; then 0x3,0x3,0x3,0x2 -> oMode4Bit=1.
REQ-036 With LCD_RX_TIMING_CHECK_EN defined, a 5-cycle E pulse -> oTimingError pulse, state unchanged; without it -> nibble accepted.
REQ-037 After one nibble 0x2 (RS=0), assert Reset -> all outputs 0, ST_INIT; a subsequent single nibble produces no oByteValid.
REQ-038 High nibble RS=0 0x2, low nibble RS=1 0x8 -> oSeqError pulse, no oByteValid; then RS=1 0x5 -> oByteValid, oByte=0x85, oByteIsData=1.
